rrf_commit_buffer: RTL and testbench
====================================

Name: rrf_commit_buffer

Overview:
- Rename register file (RRF) with in-order commit. It is the producer side of the ARF completion interface.
- Allocates rename tags at dispatch and drives the ARF set-busy port.
- Captures execution-unit writebacks, serves operand reads by tag, and retires the oldest finished entry each cycle.
- Retirement drives completed_dst_num / data / rrftag / we into the ARF.

Parameters:
DATA_LEN, 64, operand/result width
REG_SEL, 5, architectural register index width
RRF_SEL, 6, rename tag width
RRF_NUM, 64, entry count (= 2**RRF_SEL)

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-high reset
flush_i  in  1  synchronous discard of all in-flight entries
alloc_req_i  in  1  dispatch requests one entry
alloc_dst_num_i  in  REG_SEL  destination architectural register
alloc_dst_en_i  in  1  instruction writes a register
alloc_rdy_o  out  1  entry available (not full, not flush)
alloc_rrftag_o  out  RRF_SEL  tag granted (tail pointer)
dst_num_setbusy_o  out  REG_SEL  to ARF: register to mark busy
dst_rrftag_setbusy_o  out  RRF_SEL  to ARF: owning tag
dst_en_setbusy_o  out  1  to ARF: set-busy strobe
wb_en_i  in  1  result writeback strobe
wb_rrftag_i  in  RRF_SEL  writeback target tag
wb_data_i  in  DATA_LEN  result
rs1_rrftag_i, rs2_rrftag_i  in  RRF_SEL  operand lookup tags
rs1_rrf_data_o, rs2_rrf_data_o  out  DATA_LEN  stored data for tag
rs1_rrf_valid_o, rs2_rrf_valid_o  out  1  tag has been written back
completed_dst_num_o  out  REG_SEL  to ARF: retiring register
completed_dst_rrftag_o  out  RRF_SEL  to ARF: retiring tag
from_rrfdata_o  out  DATA_LEN  to ARF: retiring data
completed_we_o  out  1  to ARF: write strobe
retire_o  out  1  an entry retired (including dst_en=0 entries)

Behaviour:
- Reset (async, reset_i=1): head=tail=0, count=0, all entry valid/used bits=0, all registered outputs 0. Data array is not reset.
- Per-entry state: used, valid, dst_num, dst_en, data.
- Occupancy: count 0..RRF_NUM. Full when count==RRF_NUM; empty when count==0.
- Allocation (combinational grant): alloc_rdy_o = (count!=RRF_NUM) & ~flush_i. alloc_rrftag_o = tail always.
  - Fire = alloc_req_i & alloc_rdy_o.
  - On fire, at the edge: entry[tail].used=1, valid=0, dst_num/dst_en captured; tail+1 mod RRF_NUM.
  - Set-busy outputs are combinational: dst_en_setbusy_o = fire & alloc_dst_en_i; num/tag = alloc_dst_num_i / tail.
  - alloc_rdy_o uses the current count. No allocation while full, even if a retire happens in the same cycle.
- Writeback: on wb_en_i with entry[wb_rrftag_i].used=1, at the edge set valid=1 and store data. Writeback to an unused tag is ignored. Repeated writeback to the same tag overwrites.
- Operand read: combinational from array state. valid_o = used & valid. No same-cycle writeback bypass; the value is visible the cycle after the wb edge.
- Commit: retire condition = entry[head].used & entry[head].valid & ~flush_i, at most one per cycle.
  - At the edge: registered outputs load completed_dst_num_o=dst_num, completed_dst_rrftag_o=head, from_rrfdata_o=data, completed_we_o=dst_en, retire_o=1. Entry used is cleared; head+1 mod RRF_NUM.
  - When not retiring: completed_we_o=0, retire_o=0; other completion outputs hold.
  - Latency: writeback edge N → earliest retire edge N+1 → ARF write at edge N+2.
- count update: +1 on alloc fire, −1 on retire, unchanged when both occur.
- Wrap-around: head and tail wrap independently. The full/empty decision comes from count, not from pointer equality.
- flush_i (synchronous, highest non-reset priority): at the edge clear all used/valid bits, head=tail=count=0, completed_we_o=0, retire_o=0. The same-cycle alloc, writeback and retire are suppressed.
- Reset mid-operation: immediate return to reset state regardless of the clock.

Test Plan:
- Reset, then alloc x1 (dst_en=1) → tag 0 with setbusy(num=1, tag=0, en=1); next cycle alloc x2 → tag 1; alloc_rdy_o stays 1 and count=2.
- wb tag0 data 0x0E → the next cycle rs1_rrftag_i=0 reads data 0x0E, valid=1; at that edge completed_we_o=1, num=1, tag=0, from_rrfdata_o=0x0E.
- wb tag1 before tag0 → no retire until tag0 is written back; then tag0 and tag1 retire on consecutive cycles in order.
- Alloc with dst_en=0, write it back → retire_o=1, completed_we_o=0, and no setbusy strobe was issued at allocation.
- Allocate 64 entries → alloc_rdy_o=0. With head valid, simultaneous alloc_req and retire → retire only, count=63, alloc_rdy_o=1 the next cycle. Continue allocating: tail wraps 63→0.
- Mid-stream flush_i with 5 entries allocated and 3 written back → next cycle count=0, alloc_rrftag_o=0, all valid_o=0, no completed_we_o pulse afterwards. Assert reset_i mid-cycle → outputs clear without a clock edge.

Source files
------------

// File: rtl/rrf_commit_buffer.sv
// Rename register file with in-order commit.
// Dispatch allocates a rename tag at the tail and tells the ARF to mark the
// destination busy; execution units write results back by tag; the oldest
// entry retires once its result is present and drives the ARF write port.
//
// Allocation handshake: a grant happens on a cycle where alloc_req_i and
// alloc_rdy_o are both high; alloc_rrftag_o names the granted tag in that
// same cycle, and alloc_req_i with alloc_rdy_o low is simply not granted.
module rrf_commit_buffer #(
    parameter int DATA_LEN = 64,
    parameter int REG_SEL  = 5,
    parameter int RRF_SEL  = 6,
    parameter int RRF_NUM  = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    input  logic                alloc_req_i,
    input  logic [REG_SEL-1:0]  alloc_dst_num_i,
    input  logic                alloc_dst_en_i,
    output logic                alloc_rdy_o,
    output logic [RRF_SEL-1:0]  alloc_rrftag_o,
    output logic [REG_SEL-1:0]  dst_num_setbusy_o,
    output logic [RRF_SEL-1:0]  dst_rrftag_setbusy_o,
    output logic                dst_en_setbusy_o,
    input  logic                wb_en_i,
    input  logic [RRF_SEL-1:0]  wb_rrftag_i,
    input  logic [DATA_LEN-1:0] wb_data_i,
    input  logic [RRF_SEL-1:0]  rs1_rrftag_i,
    input  logic [RRF_SEL-1:0]  rs2_rrftag_i,
    output logic [DATA_LEN-1:0] rs1_rrf_data_o,
    output logic [DATA_LEN-1:0] rs2_rrf_data_o,
    output logic                rs1_rrf_valid_o,
    output logic                rs2_rrf_valid_o,
    output logic [REG_SEL-1:0]  completed_dst_num_o,
    output logic [RRF_SEL-1:0]  completed_dst_rrftag_o,
    output logic [DATA_LEN-1:0] from_rrfdata_o,
    output logic                completed_we_o,
    output logic                retire_o
);

    // Occupancy needs one extra bit so that "full" and "empty" differ.
    localparam int CNT_W = RRF_SEL + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RRF_NUM);

    // Per-entry state; used/valid are reset, the payload arrays are not.
    logic [RRF_NUM-1:0]  used_q;
    logic [RRF_NUM-1:0]  valid_q;
    logic [RRF_NUM-1:0]  dst_en_q;
    logic [REG_SEL-1:0]  dst_num_q [RRF_NUM];
    logic [DATA_LEN-1:0] data_q    [RRF_NUM];

    logic [RRF_SEL-1:0]  head_q, head_d;
    logic [RRF_SEL-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                alloc_fire;
    logic                wb_go;
    logic                retire_go;

    // Grant, writeback and retire qualifiers; flush suppresses all three.
    always_comb begin
        alloc_rdy_o = (count_q != FULL_CNT) & ~flush_i;
        alloc_fire  = alloc_req_i & alloc_rdy_o;
        wb_go       = wb_en_i & used_q[wb_rrftag_i] & ~flush_i;
        retire_go   = used_q[head_q] & valid_q[head_q] & ~flush_i;
    end

    // Pointer and occupancy next state; pointers wrap naturally at RRF_NUM.
    always_comb begin
        head_d  = retire_go  ? head_q + 1'b1 : head_q;
        tail_d  = alloc_fire ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        if (alloc_fire && !retire_go) begin
            count_d = count_q + CNT_W'(1);
        end else if (retire_go && !alloc_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Grant tag, ARF set-busy request and operand lookups are combinational.
    assign alloc_rrftag_o       = tail_q;
    assign dst_num_setbusy_o    = alloc_dst_num_i;
    assign dst_rrftag_setbusy_o = tail_q;
    assign dst_en_setbusy_o     = alloc_fire & alloc_dst_en_i;

    assign rs1_rrf_data_o  = data_q[rs1_rrftag_i];
    assign rs2_rrf_data_o  = data_q[rs2_rrftag_i];
    assign rs1_rrf_valid_o = used_q[rs1_rrftag_i] & valid_q[rs1_rrftag_i];
    assign rs2_rrf_valid_o = used_q[rs2_rrftag_i] & valid_q[rs2_rrftag_i];

    // Entry flags, pointers and the registered completion port.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            used_q                 <= '0;
            valid_q                <= '0;
            head_q                 <= '0;
            tail_q                 <= '0;
            count_q                <= '0;
            completed_dst_num_o    <= '0;
            completed_dst_rrftag_o <= '0;
            from_rrfdata_o         <= '0;
            completed_we_o         <= 1'b0;
            retire_o               <= 1'b0;
        end else if (flush_i) begin
            used_q         <= '0;
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            completed_we_o <= 1'b0;
            retire_o       <= 1'b0;
        end else begin
            if (wb_go) begin
                valid_q[wb_rrftag_i] <= 1'b1;
            end
            // The tail entry is never in use when a grant is possible, so this
            // cannot collide with the writeback or the retire clear.
            if (alloc_fire) begin
                used_q[tail_q]  <= 1'b1;
                valid_q[tail_q] <= 1'b0;
            end
            if (retire_go) begin
                used_q[head_q]         <= 1'b0;
                completed_dst_num_o    <= dst_num_q[head_q];
                completed_dst_rrftag_o <= head_q;
                from_rrfdata_o         <= data_q[head_q];
                completed_we_o         <= dst_en_q[head_q];
                retire_o               <= 1'b1;
            end else begin
                completed_we_o <= 1'b0;
                retire_o       <= 1'b0;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload capture at allocation and writeback; qualifiers already exclude flush.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            dst_num_q[tail_q] <= alloc_dst_num_i;
            dst_en_q[tail_q]  <= alloc_dst_en_i;
        end
        if (wb_go) begin
            data_q[wb_rrftag_i] <= wb_data_i;
        end
    end

endmodule

// File: tb/tb_rrf_commit_buffer.sv
// Bench for rrf_commit_buffer: directed dispatch/writeback/flush/reset
// sequences, a queue-based reference model checked every cycle, and
// hand-computed literal checks at the interesting points.
module tb_rrf_commit_buffer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        alloc_req_i;
    logic [4:0]  alloc_dst_num_i;
    logic        alloc_dst_en_i;
    logic        alloc_rdy_o;
    logic [5:0]  alloc_rrftag_o;
    logic [4:0]  dst_num_setbusy_o;
    logic [5:0]  dst_rrftag_setbusy_o;
    logic        dst_en_setbusy_o;
    logic        wb_en_i;
    logic [5:0]  wb_rrftag_i;
    logic [63:0] wb_data_i;
    logic [5:0]  rs1_rrftag_i, rs2_rrftag_i;
    logic [63:0] rs1_rrf_data_o, rs2_rrf_data_o;
    logic        rs1_rrf_valid_o, rs2_rrf_valid_o;
    logic [4:0]  completed_dst_num_o;
    logic [5:0]  completed_dst_rrftag_o;
    logic [63:0] from_rrfdata_o;
    logic        completed_we_o;
    logic        retire_o;

    rrf_commit_buffer dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .alloc_req_i(alloc_req_i), .alloc_dst_num_i(alloc_dst_num_i),
        .alloc_dst_en_i(alloc_dst_en_i), .alloc_rdy_o(alloc_rdy_o),
        .alloc_rrftag_o(alloc_rrftag_o), .dst_num_setbusy_o(dst_num_setbusy_o),
        .dst_rrftag_setbusy_o(dst_rrftag_setbusy_o), .dst_en_setbusy_o(dst_en_setbusy_o),
        .wb_en_i(wb_en_i), .wb_rrftag_i(wb_rrftag_i), .wb_data_i(wb_data_i),
        .rs1_rrftag_i(rs1_rrftag_i), .rs2_rrftag_i(rs2_rrftag_i),
        .rs1_rrf_data_o(rs1_rrf_data_o), .rs2_rrf_data_o(rs2_rrf_data_o),
        .rs1_rrf_valid_o(rs1_rrf_valid_o), .rs2_rrf_valid_o(rs2_rrf_valid_o),
        .completed_dst_num_o(completed_dst_num_o),
        .completed_dst_rrftag_o(completed_dst_rrftag_o),
        .from_rrfdata_o(from_rrfdata_o), .completed_we_o(completed_we_o),
        .retire_o(retire_o)
    );

    // Clock: 10 time-unit period
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // In-flight entries held in program order; front is the oldest.
    typedef struct {
        logic [5:0]  tag;
        logic [4:0]  num;
        logic        en;
        logic        v;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [5:0]  m_tail;
    logic [4:0]  m_c_num;
    logic [5:0]  m_c_tag;
    logic [63:0] m_c_data;
    logic        m_c_we;
    logic        m_retire;

    function automatic int find_tag(input logic [5:0] t);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == t) return i;
        end
        return -1;
    endfunction

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mq.delete();
            m_tail = '0; m_c_num = '0; m_c_tag = '0; m_c_data = '0;
            m_c_we = 1'b0; m_retire = 1'b0;
        end else if (flush_i) begin
            mq.delete();
            m_tail = '0; m_c_we = 1'b0; m_retire = 1'b0;
        end else begin
            automatic bit ret  = (mq.size() > 0) && mq[0].v;
            automatic bit fire = alloc_req_i && (mq.size() != 64);
            automatic int wi   = find_tag(wb_rrftag_i);
            automatic ent_t e;
            if (ret) begin
                m_c_num = mq[0].num; m_c_tag = mq[0].tag; m_c_data = mq[0].d;
                m_c_we = mq[0].en; m_retire = 1'b1;
            end else begin
                m_c_we = 1'b0; m_retire = 1'b0;
            end
            if (wb_en_i && wi >= 0) begin
                mq[wi].v = 1'b1;
                mq[wi].d = wb_data_i;
            end
            if (ret) void'(mq.pop_front());
            if (fire) begin
                e.tag = m_tail; e.num = alloc_dst_num_i; e.en = alloc_dst_en_i;
                e.v = 1'b0; e.d = '0;
                mq.push_back(e);
                m_tail = m_tail + 6'd1;
            end
        end
    end

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge clk_i) begin
        if (chk_en && !reset_i) begin
            automatic bit exp_rdy = (mq.size() != 64) && !flush_i;
            automatic int r1 = find_tag(rs1_rrftag_i);
            automatic int r2 = find_tag(rs2_rrftag_i);
            check("m_alloc_rdy", alloc_rdy_o, exp_rdy);
            check("m_alloc_tag", alloc_rrftag_o, m_tail);
            check("m_sb_en", dst_en_setbusy_o, alloc_req_i && exp_rdy && alloc_dst_en_i);
            if (alloc_req_i && exp_rdy && alloc_dst_en_i) begin
                check("m_sb_num", dst_num_setbusy_o, alloc_dst_num_i);
                check("m_sb_tag", dst_rrftag_setbusy_o, m_tail);
            end
            check("m_rs1_valid", rs1_rrf_valid_o, (r1 >= 0) && mq[r1].v);
            check("m_rs2_valid", rs2_rrf_valid_o, (r2 >= 0) && mq[r2].v);
            if (r1 >= 0 && mq[r1].v) check("m_rs1_data", rs1_rrf_data_o, mq[r1].d);
            if (r2 >= 0 && mq[r2].v) check("m_rs2_data", rs2_rrf_data_o, mq[r2].d);
            check("m_retire", retire_o, m_retire);
            check("m_we", completed_we_o, m_c_we);
            check("m_c_num", completed_dst_num_o, m_c_num);
            check("m_c_tag", completed_dst_rrftag_o, m_c_tag);
            check("m_c_data", from_rrfdata_o, m_c_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i = 0; alloc_req_i = 0; alloc_dst_num_i = 0; alloc_dst_en_i = 0;
        wb_en_i = 0; wb_rrftag_i = 0; wb_data_i = 0;
    endtask

    task automatic set_alloc(input logic [4:0] num, input logic en);
        alloc_req_i = 1; alloc_dst_num_i = num; alloc_dst_en_i = en;
    endtask

    task automatic set_wb(input logic [5:0] tag, input logic [63:0] d);
        wb_en_i = 1; wb_rrftag_i = tag; wb_data_i = d;
    endtask

    logic [5:0] ftag [5];

    initial begin
        reset_i = 1; idle(); rs1_rrftag_i = 0; rs2_rrftag_i = 0;
        cyc(); cyc();
        reset_i = 0;
        #1;
        // Reset state
        check("rst_rdy", alloc_rdy_o, 1'b1);
        check("rst_tag", alloc_rrftag_o, 6'd0);
        check("rst_we", completed_we_o, 1'b0);
        check("rst_retire", retire_o, 1'b0);
        check("rst_rs1_valid", rs1_rrf_valid_o, 1'b0);
        chk_en = 1'b1;

        // Two allocations
        set_alloc(5'd1, 1'b1); #1;
        check("a0_sb_en", dst_en_setbusy_o, 1'b1);
        check("a0_sb_num", dst_num_setbusy_o, 5'd1);
        check("a0_sb_tag", dst_rrftag_setbusy_o, 6'd0);
        cyc();
        set_alloc(5'd2, 1'b1); #1;
        check("a1_tag", alloc_rrftag_o, 6'd1);
        cyc();
        idle(); #1;
        check("a1_rdy", alloc_rdy_o, 1'b1);

        // Writeback tag0 -> readable next cycle -> retires at that edge
        set_wb(6'd0, 64'h0E);
        cyc();
        idle(); rs1_rrftag_i = 6'd0; rs2_rrftag_i = 6'd1; #1;
        check("wb0_rs1_data", rs1_rrf_data_o, 64'h0E);
        check("wb0_rs1_valid", rs1_rrf_valid_o, 1'b1);
        check("wb0_rs2_valid", rs2_rrf_valid_o, 1'b0);
        cyc();
        check("c0_we", completed_we_o, 1'b1);
        check("c0_num", completed_dst_num_o, 5'd1);
        check("c0_tag", completed_dst_rrftag_o, 6'd0);
        check("c0_data", from_rrfdata_o, 64'h0E);

        // Out-of-order writeback: tag2 before tag1
        set_alloc(5'd3, 1'b1); cyc();
        idle(); set_wb(6'd2, 64'h22); cyc();
        idle(); cyc();
        check("ooo_no_retire", retire_o, 1'b0);
        set_wb(6'd1, 64'h11); cyc();
        idle(); cyc();
        check("ooo_c1_tag", completed_dst_rrftag_o, 6'd1);
        check("ooo_c1_data", from_rrfdata_o, 64'h11);
        check("ooo_c1_num", completed_dst_num_o, 5'd2);
        cyc();
        check("ooo_c2_tag", completed_dst_rrftag_o, 6'd2);
        check("ooo_c2_data", from_rrfdata_o, 64'h22);
        check("ooo_c2_we", completed_we_o, 1'b1);

        // Entry with no destination register
        set_alloc(5'd7, 1'b0); #1;
        check("nodst_sb_en", dst_en_setbusy_o, 1'b0);
        check("nodst_tag", alloc_rrftag_o, 6'd3);
        cyc();
        idle(); set_wb(6'd3, 64'h33); cyc();
        idle(); cyc();
        check("nodst_retire", retire_o, 1'b1);
        check("nodst_we", completed_we_o, 1'b0);
        check("nodst_ctag", completed_dst_rrftag_o, 6'd3);

        // Fill to 64 entries (tail starts at 4 and wraps 63 -> 0)
        for (int i = 0; i < 64; i++) begin
            set_alloc(5'(i), 1'b1);
            cyc();
        end
        idle(); #1;
        check("full_rdy", alloc_rdy_o, 1'b0);
        check("full_tag", alloc_rrftag_o, 6'd4);
        set_wb(6'd4, 64'h44); cyc();
        idle(); set_alloc(5'd9, 1'b1); #1;
        check("full_retire_rdy", alloc_rdy_o, 1'b0);
        cyc();
        check("full_retire", retire_o, 1'b1);
        check("full_retire_tag", completed_dst_rrftag_o, 6'd4);
        check("after_retire_rdy", alloc_rdy_o, 1'b1);
        cyc();
        idle(); #1;
        check("refull_rdy", alloc_rdy_o, 1'b0);
        // Write back every in-flight tag in descending order
        for (int t = 4; t >= 0; t--) begin
            set_wb(6'(t), {$urandom, $urandom}); cyc();
        end
        for (int t = 63; t >= 5; t--) begin
            set_wb(6'(t), {$urandom, $urandom}); rs1_rrftag_i = 6'(t + 1); cyc();
        end
        idle();
        for (int i = 0; i < 70; i++) cyc();
        check("drain_rdy", alloc_rdy_o, 1'b1);

        // Flush with 5 in flight, 3 written back (head left pending)
        for (int k = 0; k < 5; k++) begin
            set_alloc(5'(k + 10), 1'b1); #1;
            ftag[k] = alloc_rrftag_o;
            cyc();
        end
        idle();
        for (int k = 1; k < 4; k++) begin
            set_wb(ftag[k], 64'h100 + 64'(k)); cyc();
        end
        idle(); rs1_rrftag_i = ftag[1]; rs2_rrftag_i = ftag[2]; #1;
        check("pre_flush_rs1_valid", rs1_rrf_valid_o, 1'b1);
        flush_i = 1; set_alloc(5'd4, 1'b1); set_wb(ftag[0], 64'hDEAD); #1;
        check("flush_rdy", alloc_rdy_o, 1'b0);
        check("flush_sb_en", dst_en_setbusy_o, 1'b0);
        cyc();
        idle(); #1;
        check("post_flush_tag", alloc_rrftag_o, 6'd0);
        check("post_flush_rdy", alloc_rdy_o, 1'b1);
        check("post_flush_rs1_valid", rs1_rrf_valid_o, 1'b0);
        check("post_flush_rs2_valid", rs2_rrf_valid_o, 1'b0);
        check("post_flush_we", completed_we_o, 1'b0);
        set_wb(6'd0, 64'h55); cyc();
        idle(); cyc(); cyc();
        check("stale_wb_no_retire", retire_o, 1'b0);

        // Asynchronous reset mid-operation
        set_alloc(5'd9, 1'b1); cyc();
        set_alloc(5'd10, 1'b1); cyc();
        idle(); set_wb(6'd0, 64'hAB); cyc();
        idle(); rs1_rrftag_i = 6'd1; cyc();
        check("pre_rst_we", completed_we_o, 1'b1);
        check("pre_rst_num", completed_dst_num_o, 5'd9);
        #2;
        reset_i = 1; #1;
        check("arst_we", completed_we_o, 1'b0);
        check("arst_retire", retire_o, 1'b0);
        check("arst_num", completed_dst_num_o, 5'd0);
        check("arst_data", from_rrfdata_o, 64'd0);
        check("arst_tag", alloc_rrftag_o, 6'd0);
        #1;
        reset_i = 0;
        set_alloc(5'd3, 1'b1); cyc();
        idle(); set_wb(6'd0, 64'h77); cyc();
        idle(); cyc();
        check("post_rst_data", from_rrfdata_o, 64'h77);
        cyc(); cyc();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
